// File: rtl/fp_align_pipe.sv
// Two-stage significand aligner for the FP adder: orders operands by magnitude, then
// right-shifts the smaller one with guard/round/sticky. Optional flush port: ALIGN_FLUSH_EN.
module fp_align_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int SHW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef ALIGN_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W-1:0]     in_e1,
    input  logic [EXP_W-1:0]     in_e2,
    input  logic [MAN_W-1:0]     in_m1,
    input  logic [MAN_W-1:0]     in_m2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W-1:0]     out_e,
    output logic [MAN_W+2:0]     out_m_big,
    output logic [MAN_W+2:0]     out_m_small,
    output logic                 out_swap,
    output logic [SHW-1:0]       out_shift
);
    localparam int W = MAN_W + 3;

    logic             flush_s;
    logic             load2_s;
    logic [EXP_W-1:0] ee1_s, ee2_s, eb_s, es_s, diff_s;
    logic             swap_s;
    logic [MAN_W-1:0] big_s, small_s;
    logic [SHW-1:0]   diff_sat_s;
    logic [2*W-1:0]   wide_s;
    logic [W-1:0]     aligned_s;

    logic             v1_r;
    logic [MAN_W-1:0] big1_r, small1_r;
    logic [EXP_W-1:0] e1_r;
    logic [SHW-1:0]   sh1_r;
    logic             swap1_r;

`ifdef ALIGN_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign load2_s  = !out_valid || out_ready;
    assign in_ready = !flush_s && (!v1_r || load2_s);

    // Stage-1 combinational: effective exponents, magnitude ordering, saturated difference.
    always_comb begin
        ee1_s = (in_e1 == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : in_e1;
        ee2_s = (in_e2 == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : in_e2;
        swap_s = ({ee2_s, in_m2} > {ee1_s, in_m1});
        if (swap_s) begin
            big_s   = in_m2;
            small_s = in_m1;
            eb_s    = ee2_s;
            es_s    = ee1_s;
        end else begin
            big_s   = in_m1;
            small_s = in_m2;
            eb_s    = ee1_s;
            es_s    = ee2_s;
        end
        diff_s = eb_s - es_s;
        if (int'(diff_s) >= W) begin
            diff_sat_s = SHW'(W);
        end else begin
            diff_sat_s = SHW'(diff_s);
        end
    end

    // Stage-2 combinational: the lower half of the double-width shift catches every lost bit.
    always_comb begin
        wide_s    = {small1_r, 3'b000, {W{1'b0}}} >> sh1_r;
        aligned_s = {wide_s[2*W-1:W+1], wide_s[W] | (|wide_s[W-1:0])};
    end

    // Stage-1 registers: capture the ordered operand pair on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r     <= 1'b0;
            big1_r   <= {MAN_W{1'b0}};
            small1_r <= {MAN_W{1'b0}};
            e1_r     <= {EXP_W{1'b0}};
            sh1_r    <= {SHW{1'b0}};
            swap1_r  <= 1'b0;
        end else if (flush_s) begin
            v1_r <= 1'b0;
        end else if (in_ready) begin
            v1_r <= in_valid;
            if (in_valid) begin
                big1_r   <= big_s;
                small1_r <= small_s;
                e1_r     <= eb_s;
                sh1_r    <= diff_sat_s;
                swap1_r  <= swap_s;
            end
        end
    end

    // Stage-2 / output registers: load whenever the output slot is empty or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_e       <= {EXP_W{1'b0}};
            out_m_big   <= {W{1'b0}};
            out_m_small <= {W{1'b0}};
            out_swap    <= 1'b0;
            out_shift   <= {SHW{1'b0}};
        end else if (flush_s) begin
            out_valid <= 1'b0;
        end else if (load2_s) begin
            out_valid <= v1_r;
            if (v1_r) begin
                out_e       <= e1_r;
                out_m_big   <= {big1_r, 3'b000};
                out_m_small <= aligned_s;
                out_swap    <= swap1_r;
                out_shift   <= sh1_r;
            end
        end
    end
endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe: directed cases, backpressure, async reset and a
// randomized run scored against an arithmetic reference model.
module tb_fp_align_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_e1 = 8'd0, in_e2 = 8'd0;
    logic [23:0] in_m1 = 24'd0, in_m2 = 24'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_e;
    logic [26:0] out_m_big, out_m_small;
    logic        out_swap;
    logic [7:0]  out_shift;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_out = 0;
    logic        last_acc;
    logic        prev_stall = 1'b0;
    logic [70:0] prev_obs;
    logic [70:0] q[$];
    int          qc[$];
    wire  [70:0] obs = {out_swap, out_shift, out_e, out_m_big, out_m_small};

    fp_align_pipe #(.EXP_W(8), .MAN_W(24), .SHW(8)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ALIGN_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready),
        .in_e1(in_e1), .in_e2(in_e2), .in_m1(in_m1), .in_m2(in_m2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_e(out_e), .out_m_big(out_m_big), .out_m_small(out_m_small),
        .out_swap(out_swap), .out_shift(out_shift)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Result packed as {swap, shift, e, m_big, m_small}.
    function automatic logic [70:0] ref_model(input int e1, input int m1, input int e2, input int m2);
        int ee1, ee2, eb, d;
        longint big, sml, ext, res;
        bit sw;
        ee1 = (e1 == 0) ? 1 : e1;
        ee2 = (e2 == 0) ? 1 : e2;
        sw  = (ee2 > ee1) || (ee2 == ee1 && m2 > m1);
        eb  = sw ? ee2 : ee1;
        big = sw ? longint'(m2) : longint'(m1);
        sml = sw ? longint'(m1) : longint'(m2);
        d   = eb - (sw ? ee1 : ee2);
        if (d >= 27) begin
            d   = 27;
            res = (sml != 0) ? 1 : 0;
        end else begin
            ext = sml * 8;
            res = (ext >> d) | (((ext & ((longint'(1) << d) - 1)) != 0) ? 1 : 0);
        end
        return {sw, 8'(d), 8'(eb), 27'(big * 8), 27'(res)};
    endfunction

    task automatic step(input logic iv, input logic [7:0] e1, input logic [23:0] m1,
                        input logic [7:0] e2, input logic [23:0] m2, input logic ordy,
                        input logic fl, input logic use_c, input logic [70:0] cexp);
        logic exp_rdy;
        @(negedge clk);
        in_valid = iv; in_e1 = e1; in_m1 = m1; in_e2 = e2; in_m2 = m2;
        out_ready = ordy; flush = fl;
        #1;
        exp_rdy = !fl && !(q.size() == 2 && !ordy);
        check("in_ready", 71'(in_ready), 71'(exp_rdy));
        if (prev_stall) check("hold", obs, prev_obs);
        if (q.size() != 0 && cyc - qc[0] == 1) check("latency1", 71'(out_valid), 71'(0));
        if (q.size() != 0 && cyc - qc[0] >= 2) check("valid", 71'(out_valid), 71'(1));
        if (out_valid) begin
            if (q.size() == 0) check("spurious_valid", 71'(out_valid), 71'(0));
            else check("data", obs, q[0]);
        end
        prev_stall = out_valid && !ordy;
        prev_obs   = obs;
        last_acc   = iv && in_ready;
        if (fl) begin
            q.delete(); qc.delete(); prev_stall = 1'b0;
        end else begin
            if (out_valid && ordy && q.size() != 0) begin
                void'(q.pop_front()); void'(qc.pop_front()); n_out++;
            end
            if (iv && in_ready) begin
                q.push_back(use_c ? cexp : ref_model(int'(e1), int'(m1), int'(e2), int'(m2)));
                qc.push_back(cyc);
            end
        end
        cyc++;
    endtask

    task automatic directed(input logic [7:0] e1, input logic [23:0] m1,
                            input logic [7:0] e2, input logic [23:0] m2, input logic [70:0] cexp);
        step(1'b1, e1, m1, e2, m2, 1'b1, 1'b0, 1'b1, cexp);
        step(1'b0, 8'd0, 24'd0, 8'd0, 24'd0, 1'b1, 1'b0, 1'b0, 71'd0);
        step(1'b0, 8'd0, 24'd0, 8'd0, 24'd0, 1'b1, 1'b0, 1'b0, 71'd0);
    endtask

    task automatic rand_step(input logic iv, input logic ordy);
        logic [7:0] e1, e2;
        e1 = 8'($urandom_range(0, 255));
        e2 = ($urandom_range(0, 1) == 0) ? 8'(e1 + 8'($urandom_range(0, 6)) - 8'd3)
                                         : 8'($urandom_range(0, 255));
        step(iv, e1, 24'($urandom) | 24'(($urandom_range(0, 3) != 0) ? 24'h800000 : 24'h0),
             e2, 24'($urandom) | 24'(($urandom_range(0, 3) != 0) ? 24'h800000 : 24'h0),
             ordy, 1'b0, 1'b0, 71'd0);
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 71'(out_valid), 71'(0));
        check("reset_data", obs, 71'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed(8'd130, 24'hC00000, 8'd128, 24'h800001,
                 {1'b0, 8'd2, 8'd130, 27'h6000000, 27'h1000002});
        directed(8'd127, 24'h800000, 8'd127, 24'hA00000,
                 {1'b1, 8'd0, 8'd127, 27'h5000000, 27'h4000000});
        directed(8'd3, 24'h800000, 8'd0, 24'h000004,
                 {1'b0, 8'd2, 8'd3, 27'h4000000, 27'h0000008});
        directed(8'd1, 24'h800000, 8'd0, 24'h000004,
                 {1'b0, 8'd0, 8'd1, 27'h4000000, 27'h0000020});
        directed(8'd200, 24'h800000, 8'd10, 24'h400000,
                 {1'b0, 8'd27, 8'd200, 27'h4000000, 27'h0000001});
        directed(8'd200, 24'h800000, 8'd10, 24'h000000,
                 {1'b0, 8'd27, 8'd200, 27'h4000000, 27'h0000000});

        // Four back-to-back pairs, downstream stalled on cycles 3..6.
        n_out = 0;
        k = 0;
        for (int c = 1; c <= 16; c++) begin
            rand_step(k < 4, !(c >= 3 && c <= 6));
            if (last_acc) k++;
        end
        check("bp_accepted", 71'(k), 71'(4));
        check("bp_delivered", 71'(n_out), 71'(4));

        for (int i = 0; i < 600; i++)
            rand_step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

        // Asynchronous reset between edges with both stages full.
        for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 71'(out_valid), 71'(0));
        check("async_rst_data", obs, 71'd0);
        check("async_rst_ready", 71'(in_ready), 71'(1));
        q.delete(); qc.delete(); prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) rand_step(1'b1, 1'b1);

`ifdef ALIGN_FLUSH_EN
        for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b0);
        step(1'b1, 8'd5, 24'h800000, 8'd4, 24'h800000, 1'b1, 1'b1, 1'b0, 71'd0);
        step(1'b0, 8'd0, 24'd0, 8'd0, 24'd0, 1'b1, 1'b0, 1'b0, 71'd0);
        check("flush_valid", 71'(out_valid), 71'(0));
        for (int i = 0; i < 10; i++) rand_step(1'b1, 1'b1);
`endif

        for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 24'd0, 8'd0, 24'd0, 1'b1, 1'b0, 1'b0, 71'd0);
        check("drained", 71'(q.size()), 71'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, pipelined significand-alignment stage for the floating-point adder datapath. Successor to the combinational aligner.
- Takes two unpacked operands (biased exponent + significand with hidden bit). Orders them by magnitude. Right-shifts the smaller significand by the effective exponent difference, generating guard/round/sticky.
- Two-stage pipeline with valid/ready handshake. Sits between operand unpack and the significand add/subtract stage.

Parameters:
- EXP_W, 8, exponent width in bits (8 single, 11 double).
- MAN_W, 24, significand width including hidden bit (24 single, 53 double).
- SHW, 8, shift-amount width; must satisfy 2^SHW > MAN_W+3.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, stage 1 can accept.
- in_e1, input, EXP_W, operand 1 biased exponent.
- in_e2, input, EXP_W, operand 2 biased exponent.
- in_m1, input, MAN_W, operand 1 significand (hidden bit already inserted; 0 for subnormal).
- in_m2, input, MAN_W, operand 2 significand.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts.
- out_e, output, EXP_W, effective exponent of the larger operand.
- out_m_big, output, MAN_W+3, larger significand, {m,3'b000}.
- out_m_small, output, MAN_W+3, aligned smaller significand, {shifted m, G, R, S}.
- out_swap, output, 1, 1 when operand 2 was the larger operand.
- out_shift, output, SHW, saturated shift amount applied.

Behaviour:
- Reset: all valid bits 0; out_e, out_m_big, out_m_small, out_swap, out_shift all 0. Reset takes effect immediately, including mid-transfer; in-flight data is discarded.
- Effective exponent: ee = (e == 0) ? 1 : e. This makes subnormal + normal and subnormal + subnormal correct without special cases.
- Stage 1 (registered on accept):
  - Compare {ee, m}. Swap = (ee2 > ee1) || (ee2 == ee1 && m2 > m1).
  - Equal operands: no swap.
  - Register big, small, ee_big, diff = ee_big − ee_small.
  - Saturate diff to MAN_W+3 when diff ≥ MAN_W+3.
- Stage 2 (registered):
  - Form ext = {small, 3'b000}, then shift right by the saturated diff.
  - G and R are the two bits directly below the significand LSB after the shift.
  - S is the OR of all bits shifted beyond R, plus the bits shifted past the register.
  - At saturation: mantissa field = 0, G = R = 0, S = |small.
  - diff = 0: small is passed unshifted, GRS = 000.
- Latency: 2 cycles from accept (in_valid && in_ready) to out_valid, with no stalls. Throughput: 1 per cycle.
- Handshake:
  - Each stage holds valid v1 or v2.
  - Stage 2 loads when !v2 || out_ready.
  - in_ready = !v1 || (!v2 || out_ready).
  - When stalled (out_valid && !out_ready), all outputs stay stable and no data is lost or duplicated.
  - Simultaneous accept and drain in the same cycle is legal and keeps full throughput.
- in_valid may drop without a transfer. Input data is only sampled on accept.
- Data registers need no reset beyond the values stated above. Valid bits are always reset.

Optional Feature:
- Macro: ALIGN_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit, synchronous).
  - flush = 1 clears v1 and v2 on the next edge, overriding any accept that cycle.
  - in_ready reads 0 during flush; data registers are unchanged.
- Undefined: no flush port; behaviour is exactly as above.

Test Plan:
- Normal, diff 2: e1=130, m1=0xC00000, e2=128, m2=0x800001 → after 2 cycles: out_e=130, out_m_big=0xC00000<<3, mantissa field 0x200000, GRS=010, swap=0, shift=2.
- Swap, equal exponents: e1=e2=127, m1=0x800000, m2=0xA00000 → swap=1, out_m_big=0xA00000<<3, small=0x800000<<3, GRS=000, shift=0.
- Subnormal cases:
  - e1=3, m1=0x800000, e2=0, m2=0x000004 → shift=2, mantissa field 0x000001, GRS=000.
  - e1=1, e2=0 → shift=0.
- Saturation: e1=200, m1=0x800000, e2=10, m2=0x400000 → shift=27, mantissa field 0, GRS=001. With m2=0 → GRS=000.
- Backpressure: stream 4 pairs back-to-back, out_ready=0 for cycles 3–6 → in_ready falls once both stages are full; outputs are held stable; all 4 results delivered in order with none lost or duplicated.
- Async reset asserted mid-stream (between edges) → out_valid=0 and all outputs 0 immediately. With ALIGN_FLUSH_EN: flush pulse with both stages full → out_valid=0 next cycle.
